// File: rtl/rijndael_roundkey_stream_pkg.sv
// rijndael_pkg: shared word type, round-constant seed and S-box helpers
// used by the round-key stream and its schedule-step datapath.
package rijndael_pkg;
   typedef logic [31:0] word_t;
   localparam logic [7:0] RC_INIT = 8'h01;
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic int rijndael_nr(input int nk, input int nb);
      return (nk > nb ? nk : nb) + 6;
   endfunction
   function automatic word_t sub_word(input word_t w);
      return {SBOX[{w[31:24], 3'b000} +: 8], SBOX[{w[23:16], 3'b000} +: 8],
              SBOX[{w[15:8], 3'b000} +: 8], SBOX[{w[7:0], 3'b000} +: 8]};
   endfunction
endpackage

// File: rtl/rijndael_roundkey_stream_keyschedulestep.sv
// rijndael_keyschedulestep: one key-expansion step, NK words in -> next NK words out.
module rijndael_keyschedulestep import rijndael_pkg::*; #(
   parameter int NK = 4
) (
   input  word_t [NK-1:0] keystate,
   input  logic  [7:0]    rc,
   output word_t [NK-1:0] next_keystate
);
   always_comb begin
      word_t acc;
      acc = keystate[0] ^ sub_word({keystate[NK-1][23:0], keystate[NK-1][31:24]}) ^ {rc, 24'h0};
      next_keystate[0] = acc;
      for (int j = 1; j < NK; j++) begin
         acc = acc ^ keystate[j];
         next_keystate[j] = acc;
      end
   end
endmodule

// File: rtl/rijndael_roundkey_stream.sv
// rijndael_roundkey_stream: sequential key expansion re-sliced into NB-word round keys.
// One schedule step per cycle fills an NK+NB word buffer that drains NB words per handshake.
module rijndael_roundkey_stream import rijndael_pkg::*; #(
   parameter int NK = 4,
   parameter int NB = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic [32*NK-1:0] key,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic [32*NB-1:0] rk_data,
   output logic [3:0]       rk_round,
   output logic             rk_last
);
   localparam int NR = rijndael_nr(NK, NB);
   localparam int TOTAL = NB * (NR + 1);
   localparam int D = NK + NB;
   localparam int CW = $clog2(D + 1);
   if (NK < 4 || NK > 6 || NB < 4 || NB > 8) begin : g_bad_params
      $error("rijndael_roundkey_stream: NK must be 4..6 and NB 4..8");
   end
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;
   word_t wbuf [D];
   word_t wbuf_n [D];
   word_t [NK-1:0] keystate, keystate_n, step_words;
   logic [CW-1:0] count, count_n;
   logic [7:0] gen, gen_n, rc, rc_n;
   logic [3:0] round_n;
   logic step, pop;
   rijndael_keyschedulestep #(.NK(NK)) u_step (
      .keystate(keystate),
      .rc(rc),
      .next_keystate(step_words)
   );
   assign key_ready = state == IDLE;
   assign rk_valid = state == RUN && count >= CW'(NB);
   assign rk_last = rk_valid && rk_round == 4'(NR);
   // a step only fires when its NK words are guaranteed to fit behind the head
   assign step = state == RUN && gen < 8'(TOTAL) && count <= CW'(NB);
   assign pop = rk_valid && rk_ready;
   always_comb begin
      rk_data = '0;
      for (int i = 0; i < NB; i++) rk_data[32*i +: 32] = wbuf[i];
   end
   always_comb begin
      state_n = state;
      wbuf_n = wbuf;
      keystate_n = keystate;
      count_n = count;
      gen_n = gen;
      rc_n = rc;
      round_n = rk_round;
      if (key_valid && key_ready) begin
         state_n = RUN;
         keystate_n = key;
         gen_n = 8'(NK);
         rc_n = RC_INIT;
         count_n = CW'(NK);
         for (int i = 0; i < NK; i++) wbuf_n[i] = key[32*i +: 32];
      end
      if (pop) begin
         for (int i = 0; i < NK; i++) wbuf_n[i] = wbuf[i+NB];
         for (int i = NK; i < D; i++) wbuf_n[i] = '0;
         count_n = count - CW'(NB);
         round_n = rk_round + 4'd1;
      end
      if (step) begin
         keystate_n = step_words;
         gen_n = gen + 8'(NK);
         rc_n = xtime(rc);
         for (int i = 0; i < D; i++)
            for (int j = 0; j < NK; j++)
               if (i == int'(count_n) + j) wbuf_n[i] = step_words[j];
         count_n = count_n + CW'(NK);
      end
      // overshoot words from the final step are dropped with the last pop
      if (pop && rk_last) begin
         state_n = IDLE;
         wbuf_n = '{default: '0};
         count_n = '0;
         round_n = '0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         wbuf <= '{default: '0};
         keystate <= '0;
         count <= '0;
         gen <= '0;
         rc <= RC_INIT;
         rk_round <= '0;
      end else begin
         state <= state_n;
         wbuf <= wbuf_n;
         keystate <= keystate_n;
         count <= count_n;
         gen <= gen_n;
         rc <= rc_n;
         rk_round <= round_n;
      end
   end
endmodule

// File: tb/tb_rijndael_roundkey_stream.sv
// tb_rijndael_roundkey_stream: directed FIPS-197 vectors on AES-128, AES-192 and NB=8 configurations.
module tb_rijndael_roundkey_stream;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int tests = 0;
   int failed = 0;
   localparam logic [127:0] K128 = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
   localparam logic [127:0] R1 = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
   localparam logic [127:0] R2 = 128'h7359f67f_5935807a_7a96b943_f2c295f2;
   localparam logic [127:0] R3 = 128'h6d7a883b_1e237e44_4716fe3e_3d80477d;
   localparam logic [127:0] R10 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
   localparam logic [191:0] K192 = 192'h522c6b7b_62f8ead2_809079e5_c810f32b_da0e6452_8e73b0f7;
   localparam logic [127:0] R1_192 = 128'h2402f5a5_fe0c91f7_522c6b7b_62f8ead2;
   localparam logic [127:0] R12_192 = 128'h01002202_8ecc7204_448c773c_e98ba06f;
   logic a_key_valid = 0, a_key_ready, a_rk_valid, a_rk_ready = 1, a_rk_last;
   logic [127:0] a_key = '0, a_rk_data;
   logic [3:0] a_rk_round;
   logic b_key_valid = 0, b_key_ready, b_rk_valid, b_rk_ready = 1, b_rk_last;
   logic [191:0] b_key = '0;
   logic [127:0] b_rk_data;
   logic [3:0] b_rk_round;
   logic c_key_valid = 0, c_key_ready, c_rk_valid, c_rk_ready = 1, c_rk_last;
   logic [127:0] c_key = '0;
   logic [255:0] c_rk_data;
   logic [3:0] c_rk_round;
   rijndael_roundkey_stream #(.NK(4), .NB(4)) dut_a (
      .clk(clk), .rst(rst), .key_valid(a_key_valid), .key_ready(a_key_ready), .key(a_key),
      .rk_valid(a_rk_valid), .rk_ready(a_rk_ready), .rk_data(a_rk_data), .rk_round(a_rk_round), .rk_last(a_rk_last));
   rijndael_roundkey_stream #(.NK(6), .NB(4)) dut_b (
      .clk(clk), .rst(rst), .key_valid(b_key_valid), .key_ready(b_key_ready), .key(b_key),
      .rk_valid(b_rk_valid), .rk_ready(b_rk_ready), .rk_data(b_rk_data), .rk_round(b_rk_round), .rk_last(b_rk_last));
   rijndael_roundkey_stream #(.NK(4), .NB(8)) dut_c (
      .clk(clk), .rst(rst), .key_valid(c_key_valid), .key_ready(c_key_ready), .key(c_key),
      .rk_valid(c_rk_valid), .rk_ready(c_rk_ready), .rk_data(c_rk_data), .rk_round(c_rk_round), .rk_last(c_rk_last));

   function automatic logic [128:0] exp128(input int r);
      case (r)
         0: return {1'b1, K128};
         1: return {1'b1, R1};
         2: return {1'b1, R2};
         3: return {1'b1, R3};
         10: return {1'b1, R10};
         default: return '0;
      endcase
   endfunction

   // returns at the negedge one cycle after the key handshake
   task automatic load(input int which, input logic [191:0] k);
      bit rdy;
      @(negedge clk);
      if (which == 0) begin a_key = k[127:0]; a_key_valid = 1; end
      if (which == 1) begin b_key = k; b_key_valid = 1; end
      if (which == 2) begin c_key = k[127:0]; c_key_valid = 1; end
      rdy = 0;
      for (int c = 0; c < 10 && !rdy; c++) begin
         rdy = which == 0 ? a_key_ready : which == 1 ? b_key_ready : c_key_ready;
         if (!rdy) @(negedge clk);
      end
      @(negedge clk);
      a_key_valid = 0;
      b_key_valid = 0;
      c_key_valid = 0;
      tests++;
      if (!rdy) begin failed++; $display("FAIL load_key_ready dut%0d got 0 exp 1", which); end
   endtask

   task automatic test_reset;
      rst = 1;
      @(negedge clk);
      tests++;
      if (a_key_ready !== 1'b1) begin failed++; $display("FAIL reset_key_ready got %b exp 1", a_key_ready); end
      tests++;
      if (a_rk_valid !== 1'b0 || a_rk_last !== 1'b0) begin failed++; $display("FAIL reset_valid_last got %b%b exp 00", a_rk_valid, a_rk_last); end
      tests++;
      if (a_rk_round !== 4'd0 || a_rk_data !== '0) begin failed++; $display("FAIL reset_round_data got %0d %h exp 0 0", a_rk_round, a_rk_data); end
      tests++;
      if (b_key_ready !== 1'b1 || c_key_ready !== 1'b1 || b_rk_valid !== 1'b0 || c_rk_valid !== 1'b0) begin
         failed++; $display("FAIL reset_other_duts got %b%b%b%b exp 1100", b_key_ready, c_key_ready, b_rk_valid, c_rk_valid);
      end
      rst = 0;
   endtask

   task automatic test_aes128;
      int n;
      bit done;
      logic [128:0] e;
      load(0, {64'h0, K128});
      a_key = ~K128;
      a_key_valid = 1;
      tests++;
      if (a_rk_valid !== 1'b1 || a_rk_round !== 4'd0) begin failed++; $display("FAIL aes128_latency got v=%b r=%0d exp v=1 r=0", a_rk_valid, a_rk_round); end
      n = 0;
      done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (c > 0) @(negedge clk);
         tests++;
         if (a_rk_valid !== 1'b1 || a_key_ready !== 1'b0) begin failed++; $display("FAIL aes128_throughput cycle %0d got v=%b kr=%b exp v=1 kr=0", c, a_rk_valid, a_key_ready); end
         if (a_rk_valid) begin
            e = exp128(n);
            tests++;
            if (a_rk_round !== 4'(n) || a_rk_last !== (n == 10)) begin failed++; $display("FAIL aes128_round got r=%0d last=%b exp r=%0d", a_rk_round, a_rk_last, n); end
            if (e[128]) begin
               tests++;
               if (a_rk_data !== e[127:0]) begin failed++; $display("FAIL aes128_data round %0d got %h exp %h", n, a_rk_data, e[127:0]); end
            end
            if (a_rk_last) begin done = 1; a_key_valid = 0; end
            n++;
         end
      end
      tests++;
      if (!done || n != 11) begin failed++; $display("FAIL aes128_pops got %0d exp 11", n); end
      @(negedge clk);
      tests++;
      if (a_key_ready !== 1'b1 || a_rk_valid !== 1'b0) begin failed++; $display("FAIL aes128_idle_after got kr=%b v=%b exp kr=1 v=0", a_key_ready, a_rk_valid); end
   endtask

   task automatic test_backpressure;
      int n;
      bit done, stalled;
      logic [128:0] e;
      load(0, {64'h0, K128});
      n = 0;
      done = 0;
      stalled = 0;
      for (int c = 0; c < 80 && !done; c++) begin
         if (c > 0) @(negedge clk);
         if (a_rk_valid) begin
            if (a_rk_round == 4'd3 && !stalled) begin
               stalled = 1;
               a_rk_ready = 0;
               for (int s = 0; s < 20; s++) begin
                  @(negedge clk);
                  tests++;
                  if (a_rk_valid !== 1'b1 || a_rk_round !== 4'd3 || a_rk_data !== R3) begin
                     failed++; $display("FAIL bp_hold cycle %0d got v=%b r=%0d d=%h exp v=1 r=3 d=%h", s, a_rk_valid, a_rk_round, a_rk_data, R3);
                  end
               end
               a_rk_ready = 1;
            end
            e = exp128(n);
            tests++;
            if (a_rk_round !== 4'(n)) begin failed++; $display("FAIL bp_round got %0d exp %0d", a_rk_round, n); end
            if (e[128]) begin
               tests++;
               if (a_rk_data !== e[127:0]) begin failed++; $display("FAIL bp_data round %0d got %h exp %h", n, a_rk_data, e[127:0]); end
            end
            if (a_rk_last) done = 1;
            n++;
         end
      end
      tests++;
      if (!done || n != 11 || !stalled) begin failed++; $display("FAIL bp_pops got %0d stalled=%b exp 11 stalled=1", n, stalled); end
      @(negedge clk);
   endtask

   task automatic test_aes192;
      int n;
      bit done;
      load(1, K192);
      n = 0;
      done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         if (c > 0) @(negedge clk);
         if (b_rk_valid) begin
            tests++;
            if (b_rk_round !== 4'(n) || b_rk_last !== (n == 12)) begin failed++; $display("FAIL aes192_round got r=%0d last=%b exp r=%0d", b_rk_round, b_rk_last, n); end
            if (n == 0 || n == 1 || n == 12) begin
               tests++;
               if (b_rk_data !== (n == 0 ? K192[127:0] : n == 1 ? R1_192 : R12_192)) begin
                  failed++; $display("FAIL aes192_data round %0d got %h", n, b_rk_data);
               end
            end
            if (b_rk_last) done = 1;
            n++;
         end
      end
      tests++;
      if (!done || n != 13) begin failed++; $display("FAIL aes192_pops got %0d exp 13", n); end
      @(negedge clk);
      tests++;
      if (b_key_ready !== 1'b1) begin failed++; $display("FAIL aes192_idle_after got %b exp 1", b_key_ready); end
   endtask

   task automatic test_nb8;
      int n;
      bit done;
      load(2, {64'h0, K128});
      tests++;
      if (c_rk_valid !== 1'b0) begin failed++; $display("FAIL nb8_gated got %b exp 0", c_rk_valid); end
      n = 0;
      done = 0;
      for (int c = 0; c < 80 && !done; c++) begin
         if (c > 0) @(negedge clk);
         if (c_rk_valid) begin
            tests++;
            if (c_rk_round !== 4'(n) || c_rk_last !== (n == 14)) begin failed++; $display("FAIL nb8_round got r=%0d last=%b exp r=%0d", c_rk_round, c_rk_last, n); end
            if (n == 0) begin
               tests++;
               if (c_rk_data !== {R1, K128}) begin failed++; $display("FAIL nb8_round0 got %h exp %h", c_rk_data, {R1, K128}); end
            end
            if (n == 5) begin
               tests++;
               if (c_rk_data[127:0] !== R10) begin failed++; $display("FAIL nb8_round5 got %h exp %h", c_rk_data[127:0], R10); end
            end
            if (c_rk_last) done = 1;
            n++;
         end
      end
      tests++;
      if (!done || n != 15) begin failed++; $display("FAIL nb8_pops got %0d exp 15", n); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int n;
      bit done;
      logic [128:0] e;
      load(0, {64'h0, K128});
      n = 0;
      for (int c = 0; c < 30 && n < 5; c++) begin
         if (c > 0) @(negedge clk);
         if (a_rk_valid) n++;
      end
      @(posedge clk);
      #2 rst = 1;
      #1;
      tests++;
      if (a_key_ready !== 1'b1 || a_rk_valid !== 1'b0 || a_rk_round !== 4'd0 || a_rk_data !== '0) begin
         failed++; $display("FAIL reset_mid got kr=%b v=%b r=%0d exp kr=1 v=0 r=0", a_key_ready, a_rk_valid, a_rk_round);
      end
      @(negedge clk);
      rst = 0;
      load(0, {64'h0, K128});
      n = 0;
      done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (c > 0) @(negedge clk);
         if (a_rk_valid) begin
            e = exp128(n);
            tests++;
            if (a_rk_round !== 4'(n)) begin failed++; $display("FAIL reload_round got %0d exp %0d", a_rk_round, n); end
            if (e[128]) begin
               tests++;
               if (a_rk_data !== e[127:0]) begin failed++; $display("FAIL reload_data round %0d got %h exp %h", n, a_rk_data, e[127:0]); end
            end
            if (a_rk_last) done = 1;
            n++;
         end
      end
      tests++;
      if (!done || n != 11) begin failed++; $display("FAIL reload_pops got %0d exp 11", n); end
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_aes128;
      test_backpressure;
      test_aes192;
      test_nb8;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
